// File: rtl/pe_stream_sender_pkg.sv
// Shared definitions for the PE stream sender: FSM encoding and stream bus geometry.
package pe_stream_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the {enable, data} bus presented to a PE input port.
    function automatic int stream_w(input int lanes, input int data_size);
        return lanes * data_size + 1;
    endfunction

    // Bit position of the enable flag (MSB of the stream bus).
    function automatic int en_bit(input int lanes, input int data_size);
        return lanes * data_size;
    endfunction

endpackage

// File: rtl/pe_stream_sender_fifo.sv
// Small synchronous prefetch FIFO; the head word is visible combinationally on o_head.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A push into a full FIFO is only allowed when the head leaves in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pe_stream_sender.sv
// Streams a burst of GLB words into one PE input port, prefetching through a small FIFO
// so a word can be offered every cycle the PE is ready.
module pe_stream_sender
    import pe_stream_sender_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_BIT   = 16,
    parameter int LEN_BIT    = 12
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [ADDR_BIT-1:0]                    base_addr,
    input  logic [LEN_BIT-1:0]                     burst_len,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   src_req,
    output logic [ADDR_BIT-1:0]                    src_addr,
    input  logic                                   src_rvalid,
    input  logic [LANES*DATA_SIZE-1:0]             src_rdata,
    output logic [stream_w(LANES, DATA_SIZE)-1:0]  stream_out,
    input  logic                                   stream_ready,
    output state_t                                 dbg_state
);
    localparam int DW = LANES * DATA_SIZE;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_BIT-1:0] r_base;
    logic [LEN_BIT-1:0]  r_len;
    logic [LEN_BIT-1:0]  r_issued;
    logic [LEN_BIT-1:0]  r_accepted;
    logic [LEN_BIT-1:0]  w_acc_nxt;
    logic                r_inflight;
    logic                w_push;
    logic                w_pop;
    logic                w_req;
    logic                w_empty;
    logic                w_full;
    logic [CW-1:0]       w_count;
    logic [CW:0]         w_used;
    logic [DW-1:0]       w_head;

    stream_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (src_rdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop     = !w_empty && stream_ready;
    assign w_push    = src_rvalid && (r_state == ST_RUN);
    assign w_acc_nxt = r_accepted + LEN_BIT'(w_pop);

    // Slots committed after this cycle if a new request goes out: a word leaving the head
    // this cycle already frees its slot.
    assign w_used = (CW+1)'(w_count) + (CW+1)'(r_inflight) + (CW+1)'(1) - (CW+1)'(w_pop);

    assign w_req = (r_state == ST_RUN) && (r_issued < r_len)
                && (w_used <= (CW+1)'(FIFO_DEPTH)) && !(w_full && !w_pop);

    assign src_req    = w_req;
    assign src_addr   = w_req ? (r_base + ADDR_BIT'(r_issued)) : '0;
    assign stream_out = w_empty ? '0 : {1'b1, w_head};
    assign dbg_state  = r_state;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if ((r_issued == r_len) && (w_acc_nxt == r_len)) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Read latency is exactly one cycle, so a request is in flight only for one cycle.
            r_inflight <= w_req;
            if ((r_state == ST_IDLE) && start) begin
                r_base     <= base_addr;
                r_len      <= burst_len;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_req) r_issued <= r_issued + LEN_BIT'(1);
                r_accepted <= w_acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_pe_stream_sender.sv
// Bench for pe_stream_sender: one LANES=1 and one LANES=4 instance, GLB models, ready
// drivers, and a scoreboard of expected words/addresses derived from the burst parameters.
module tb_pe_stream_sender;
  import pe_stream_sender_pkg::*;

  localparam int DS    = 8;
  localparam int DEPTH = 4;
  localparam int AB    = 16;
  localparam int LB    = 12;
  localparam int EA    = en_bit(1, DS);
  localparam int EB    = en_bit(4, DS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          a_start, a_busy, a_done, a_req, a_rvalid, a_ready;
  logic [AB-1:0] a_base, a_addr;
  logic [LB-1:0] a_len;
  logic [7:0]    a_rdata;
  logic [EA:0]   a_out;
  state_t        a_state;

  logic          b_start, b_busy, b_done, b_req, b_rvalid, b_ready;
  logic [AB-1:0] b_base, b_addr;
  logic [LB-1:0] b_len;
  logic [31:0]   b_rdata;
  logic [EB:0]   b_out;
  state_t        b_state;

  pe_stream_sender #(.DATA_SIZE(DS), .LANES(1), .FIFO_DEPTH(DEPTH), .ADDR_BIT(AB), .LEN_BIT(LB)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .base_addr(a_base), .burst_len(a_len),
    .busy(a_busy), .done(a_done), .src_req(a_req), .src_addr(a_addr),
    .src_rvalid(a_rvalid), .src_rdata(a_rdata), .stream_out(a_out),
    .stream_ready(a_ready), .dbg_state(a_state)
  );

  pe_stream_sender #(.DATA_SIZE(DS), .LANES(4), .FIFO_DEPTH(DEPTH), .ADDR_BIT(AB), .LEN_BIT(LB)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .base_addr(b_base), .burst_len(b_len),
    .busy(b_busy), .done(b_done), .src_req(b_req), .src_addr(b_addr),
    .src_rvalid(b_rvalid), .src_rdata(b_rdata), .stream_out(b_out),
    .stream_ready(b_ready), .dbg_state(b_state)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]    exp_qa[$];
  logic [31:0]   exp_qb[$];
  logic [AB-1:0] addr_qa[$];
  logic [AB-1:0] addr_qb[$];
  int n_req_a, n_acc_a, n_done_a, n_req_b, n_acc_b, n_done_b;
  int a_rmode = 0, b_rmode = 0, a_rk = 0, b_rk = 0;

  function automatic logic [7:0] glb_a(input logic [AB-1:0] ad);
    return ad[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] glb_b(input logic [AB-1:0] ad);
    return {ad[7:0] ^ 8'h3C, ad[15:8] ^ 8'h5A, ~ad[7:0], ad[15:8] + 8'h11};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input string act, input string req);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual %s, required %s", name, act, req);
  endtask

  // ---------------- GLB read models (1-cycle latency) ----------------
  initial begin : glb_model_a
    logic r;
    logic [AB-1:0] ad;
    a_rvalid = 1'b0;
    a_rdata  = '0;
    forever begin
      @(negedge clk);
      r = a_req;
      ad = a_addr;
      @(posedge clk); #1;
      a_rvalid = r;
      a_rdata  = r ? glb_a(ad) : 8'h00;
    end
  end

  initial begin : glb_model_b
    logic r;
    logic [AB-1:0] ad;
    b_rvalid = 1'b0;
    b_rdata  = '0;
    forever begin
      @(negedge clk);
      r = b_req;
      ad = b_addr;
      @(posedge clk); #1;
      b_rvalid = r;
      b_rdata  = r ? glb_b(ad) : 32'h0;
    end
  end

  // ---------------- PE ready drivers ----------------
  initial begin : ready_drv_a
    a_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (a_rmode)
        1:       a_ready = (a_rk % 3 == 0);
        2:       a_ready = 1'($urandom_range(0, 1));
        3:       a_ready = (a_rk >= 20);
        default: a_ready = 1'b1;
      endcase
      a_rk++;
    end
  end

  initial begin : ready_drv_b
    b_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      b_ready = (b_rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      b_rk++;
    end
  end

  // ---------------- monitors ----------------
  initial begin : mon_a
    logic hold, pop;
    logic [EA:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        pop = a_out[EA] && a_ready;
        if (hold) check("a_no_retract", a_out, held);
        if (a_req) begin
          n_req_a++;
          check("a_credit", 64'((n_req_a - n_acc_a - int'(pop)) <= DEPTH), 1);
          if (addr_qa.size() == 0)
            fail_evt("a_extra_req", $sformatf("request at 0x%0h", a_addr), "no request");
          else
            check("a_src_addr", a_addr, addr_qa.pop_front());
        end
        if (pop) begin
          n_acc_a++;
          if (exp_qa.size() == 0)
            fail_evt("a_extra_word", $sformatf("word 0x%0h", a_out[7:0]), "no word");
          else
            check("a_data", a_out[7:0], exp_qa.pop_front());
        end
        if (a_done) n_done_a++;
        hold = a_out[EA] && !a_ready;
        held = a_out;
      end
    end
  end

  initial begin : mon_b
    logic hold, pop;
    logic [EB:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        pop = b_out[EB] && b_ready;
        if (hold) check("b_no_retract", b_out, held);
        if (b_req) begin
          n_req_b++;
          if (addr_qb.size() == 0)
            fail_evt("b_extra_req", $sformatf("request at 0x%0h", b_addr), "no request");
          else
            check("b_src_addr", b_addr, addr_qb.pop_front());
        end
        if (pop) begin
          n_acc_b++;
          if (exp_qb.size() == 0)
            fail_evt("b_extra_word", $sformatf("word 0x%0h", b_out[31:0]), "no word");
          else
            check("b_data", b_out[31:0], exp_qb.pop_front());
        end
        if (b_done) n_done_b++;
        hold = b_out[EB] && !b_ready;
        held = b_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_a(input logic [AB-1:0] base, input int len, input int mode, input bit spur);
    int k0, c;
    bit got;
    @(posedge clk); #1;
    exp_qa.delete();
    addr_qa.delete();
    for (int i = 0; i < len; i++) begin
      exp_qa.push_back(glb_a(base + AB'(i)));
      addr_qa.push_back(base + AB'(i));
    end
    n_req_a = 0; n_acc_a = 0; n_done_a = 0;
    a_rmode = mode; a_rk = 0;
    a_start = 1'b1; a_base = base; a_len = LB'(len); k0 = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_busy_run", a_busy, 1);
    if (spur) begin
      @(posedge clk); #1;
      a_start = 1'b1; a_base = base ^ 16'h0F0F; a_len = LB'(len + 3);
      @(posedge clk); #1;
      a_start = 1'b0;
    end
    if (mode == 3) begin
      repeat (15) @(negedge clk);
      #1;
      check("a_stall_reqs", n_req_a, (len < DEPTH) ? len : DEPTH);
      check("a_stall_words", n_acc_a, 0);
    end
    got = 1'b0;
    c = 0;
    while (!got && c < 8 * len + 64) begin
      @(negedge clk);
      c++;
      if (a_done) got = 1'b1;
    end
    if (!got) begin
      fail_evt("a_done_timeout", "no done pulse", "done pulse");
    end else begin
      if (mode == 0) check("a_done_cycle", cyc - k0, (len == 0) ? 2 : len + 3);
      @(negedge clk); #1;
      check("a_busy_after", a_busy, 0);
      check("a_done_single", a_done, 0);
      check("a_words_left", exp_qa.size(), 0);
      check("a_req_total", n_req_a, len);
      check("a_done_count", n_done_a, 1);
    end
    a_rmode = 0;
  endtask

  task automatic run_b(input logic [AB-1:0] base, input int len, input int mode);
    int k0, c;
    bit got;
    @(posedge clk); #1;
    exp_qb.delete();
    addr_qb.delete();
    for (int i = 0; i < len; i++) begin
      exp_qb.push_back(glb_b(base + AB'(i)));
      addr_qb.push_back(base + AB'(i));
    end
    n_req_b = 0; n_acc_b = 0; n_done_b = 0;
    b_rmode = mode; b_rk = 0;
    b_start = 1'b1; b_base = base; b_len = LB'(len); k0 = cyc;
    @(posedge clk); #1;
    b_start = 1'b0;
    got = 1'b0;
    c = 0;
    while (!got && c < 8 * len + 64) begin
      @(negedge clk);
      c++;
      if (b_done) got = 1'b1;
    end
    if (!got) begin
      fail_evt("b_done_timeout", "no done pulse", "done pulse");
    end else begin
      if (mode == 0) check("b_done_cycle", cyc - k0, (len == 0) ? 2 : len + 3);
      @(negedge clk); #1;
      check("b_busy_after", b_busy, 0);
      check("b_words_left", exp_qb.size(), 0);
      check("b_req_total", n_req_b, len);
      check("b_done_count", n_done_b, 1);
    end
    b_rmode = 0;
  endtask

  task automatic reset_mid_a();
    int c;
    @(posedge clk); #1;
    exp_qa.delete();
    addr_qa.delete();
    for (int i = 0; i < 5; i++) begin
      exp_qa.push_back(glb_a(16'h0040 + AB'(i)));
      addr_qa.push_back(16'h0040 + AB'(i));
    end
    n_req_a = 0; n_acc_a = 0; n_done_a = 0; a_rmode = 0;
    a_start = 1'b1; a_base = 16'h0040; a_len = LB'(5);
    @(posedge clk); #1;
    a_start = 1'b0;
    c = 0;
    while (n_acc_a < 2 && c < 40) begin
      @(negedge clk); #1;
      c++;
    end
    if (n_acc_a < 2) fail_evt("rst_wait_words", $sformatf("%0d words", n_acc_a), "2 words");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_done", a_done, 0);
    check("rst_mid_req", a_req, 0);
    check("rst_mid_addr", a_addr, 0);
    check("rst_mid_stream", a_out, 0);
    check("rst_mid_state", a_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_qa.delete();
    addr_qa.delete();
    repeat (10) @(negedge clk);
    #1;
    check("rst_no_done", n_done_a, 0);
    check("rst_idle_busy", a_busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    rst = 1'b0;
    a_start = 1'b0; a_base = '0; a_len = '0;
    b_start = 1'b0; b_base = '0; b_len = '0;
    repeat (3) @(negedge clk);
    check("reset_a_busy", a_busy, 0);
    check("reset_a_done", a_done, 0);
    check("reset_a_req", a_req, 0);
    check("reset_a_addr", a_addr, 0);
    check("reset_a_stream", a_out, 0);
    check("reset_a_state", a_state, ST_IDLE);
    check("reset_b_busy", b_busy, 0);
    check("reset_b_req", b_req, 0);
    check("reset_b_stream", b_out, 0);
    check("reset_b_state", b_state, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b1;

    run_a(16'h0010, 4, 0, 1'b0);   // back-to-back stream, 0xB5,0xB4,0xB7,0xB6
    run_a(16'h0010, 4, 1, 1'b0);   // ready 1,0,0 pattern
    run_a(16'h0010, 4, 3, 1'b0);   // PE stalled for 20 cycles
    run_a(16'h0123, 9, 3, 1'b0);   // stall with a burst longer than the FIFO
    run_a(16'h0200, 0, 0, 1'b0);   // empty burst
    run_a(16'h0010, 4, 0, 1'b1);   // extra start while running
    reset_mid_a();
    run_a(16'h0050, 5, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      run_a(AB'($urandom), $urandom_range(0, 12), $urandom_range(0, 2), 1'b0);

    run_b(16'hFFFE, 3, 0);         // address wrap with 32-bit words
    for (int i = 0; i < 4; i++)
      run_b(AB'($urandom), $urandom_range(1, 10), 2 * $urandom_range(0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: actual still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
